lever_frame_decoder: RTL and testbench
======================================

# lever_frame_decoder

Parametrised successor to the two-lever serial decoder in the game datapath. It consumes the UART receiver's byte stream and decodes framed packets carrying N_CH signed lever samples of W bits each. It publishes them as one registered, atomically updated vector. Frames are guarded by a sync byte, an inter-byte timeout and, optionally, an XOR checksum. It feeds the pendulum driver, level register and debug displays.

## Interface
- N_CH, 2: number of lever channels (1..8).
- W, 16: bits per channel sample; multiple of 8, 8..32; B = W/8 bytes per channel.
- TIMEOUT, 50_000: max idle cycles between bytes inside a frame (1 ms at 50 MHz).
- SYNC, 8'hA5: frame start byte.
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high; clears all state and outputs.
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte.
- rx_data  in  8  received byte.
- clear  in  1  synchronous zeroing of ch_data only; FSM unaffected.
- ch_data  out  N_CH*W  channel k at bits [k*W +: W], two's complement.
- frame_valid  out  1  one-cycle pulse when ch_data is updated.
- frame_err  out  1  one-cycle pulse on timeout or checksum mismatch.
- err_count  out  8  saturating error counter.
- busy  out  1  high while a frame is in progress (state != IDLE).
- db_state  out  2  state code: IDLE=0, PAYLOAD=1, CHECK=2.

## Operation
- Reset: state IDLE; ch_data, shadow buffer, byte index, running XOR, gap counter and err_count = 0; frame_valid, frame_err, busy = 0.
- IDLE:
  - rx_valid with rx_data==SYNC → PAYLOAD; byte index = 0; XOR = 0; gap = 0.
  - Any other byte is dropped silently and does not count as an error.
- PAYLOAD:
  - Each rx_valid writes rx_data into shadow byte [index], increments index and XORs the byte into the running XOR.
  - Byte order: channel 0 first, ascending channels; within a channel, least-significant byte first.
  - The byte with index N_CH*B-1 is the last payload byte. With checksum enabled it moves the FSM to CHECK; otherwise it commits.
  - A SYNC value inside the payload is treated as data; there is no resynchronisation.
- CHECK:
  - If rx_valid and rx_data == running XOR: commit.
  - If rx_valid and the values differ: frame_err, and the FSM returns to IDLE.
- Commit:
  - ch_data is loaded from the shadow buffer, frame_valid pulses and the FSM returns to IDLE.
  - All channels update in the same cycle; partial frames never reach ch_data.
- Timeout:
  - In PAYLOAD or CHECK, the gap counter increments every cycle without rx_valid and resets to 0 on rx_valid.
  - When gap reaches TIMEOUT-1 with no byte arriving: frame_err, then IDLE. The shadow buffer is discarded and ch_data is kept.
- err_count increments on every frame_err pulse, saturates at 255 and clears only on reset.
- clear:
  - Sets ch_data = 0 next cycle.
  - If clear coincides with a commit, the commit wins and ch_data takes the shadow value.
- Reset asserted mid-frame aborts the frame with no frame_err pulse.

## Timing
- The byte accepted in cycle t is visible in state/index at t+1.
- Commit latency: ch_data and frame_valid change in the cycle after the final byte is strobed, i.e. one clock.
- The FSM is in IDLE in that same cycle, so a SYNC strobed in the very next cycle is accepted. Back-to-back frames run with zero gap.
- frame_err asserts the cycle after the bad checksum byte, or the cycle after the gap counter expires.
- frame_valid and frame_err are never high together.
- Minimum frame length: 1 + N_CH*B (+1 with checksum) strobes.

## Configuration
- LEVER_CHECKSUM_EN defined:
  - The CHECK state and trailing XOR byte are compiled in.
  - Frame = SYNC, payload, XOR of the payload bytes.
- LEVER_CHECKSUM_EN undefined:
  - The CHECK state, XOR register and compare logic are absent.
  - Commit happens on the last payload byte; frame_err is produced by timeout only.
  - db_state never reads 2.

## Test plan
- Default parameters, checksum on:
  - Stimulus: A5,34,12,CD,AB,checksum 40.
  - Response: ch_data = 32'hABCD_1234 one cycle after the last byte; frame_valid is a single pulse; err_count = 0.
- Checksum mismatch: same frame with a trailing 41 → frame_err pulse, ch_data keeps its old value, err_count = 1, state IDLE.
- Timeout (TIMEOUT=16):
  - Stimulus: A5,34 followed by 16 idle cycles.
  - Response: frame_err, busy drops, ch_data unchanged. A following valid frame decodes correctly.
- Back-to-back:
  - Stimulus: two valid frames with zero gap, the second being A5,FF,FF,00,80,chk 80.
  - Response: two frame_valid pulses; final ch_data = 32'h8000_FFFF (ch1 = -32768, ch0 = -1).
- Noise and corner cases:
  - Bytes 00,12,FF before the sync → ignored, err_count stays 0.
  - clear in the commit cycle → the committed value wins.
  - reset asserted mid-payload → all outputs 0, no frame_err.
- N_CH=4, W=8, checksum off:
  - Stimulus: A5,01,02,03,04.
  - Response: ch_data = 32'h0403_0201 one cycle after the last byte.
- err_count saturation: 300 bad frames → err_count = 255.

Source files
------------

// File: rtl/lever_frame_decoder.sv
// Framed serial lever decoder: SYNC byte, N_CH little-endian W-bit samples, optional XOR byte.
// Define LEVER_CHECKSUM_EN to compile in the CHECK state and trailing checksum compare.
module lever_frame_decoder #(
    parameter int unsigned N_CH    = 2,
    parameter int unsigned W       = 16,
    parameter int unsigned TIMEOUT = 50_000,
    parameter logic [7:0]  SYNC    = 8'hA5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              clear,
    output logic [N_CH*W-1:0] ch_data,
    output logic              frame_valid,
    output logic              frame_err,
    output logic [7:0]        err_count,
    output logic              busy,
    output logic [1:0]        db_state
);

    localparam int unsigned NBYTES = N_CH * (W / 8);
    localparam int unsigned IdxW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int unsigned GapW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NBYTES - 1);
    localparam logic [GapW-1:0] GapLast = GapW'(TIMEOUT - 1);

`ifdef LEVER_CHECKSUM_EN
    typedef enum logic [1:0] {StIdle = 2'd0, StPayload = 2'd1, StCheck = 2'd2} state_e;
`else
    typedef enum logic [1:0] {StIdle = 2'd0, StPayload = 2'd1} state_e;
`endif

    state_e              state_q, state_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [GapW-1:0]     gap_q, gap_d;
    logic [N_CH*W-1:0]   shadow_q, shadow_d;
    logic [N_CH*W-1:0]   ch_data_q, ch_data_d;
    logic                frame_valid_q, frame_valid_d;
    logic                frame_err_q, frame_err_d;
    logic [7:0]          err_count_q, err_count_d;
`ifdef LEVER_CHECKSUM_EN
    logic [7:0]          xor_q, xor_d;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StIdle;
            idx_q         <= '0;
            gap_q         <= '0;
            shadow_q      <= '0;
            ch_data_q     <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            err_count_q   <= '0;
`ifdef LEVER_CHECKSUM_EN
            xor_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            gap_q         <= gap_d;
            shadow_q      <= shadow_d;
            ch_data_q     <= ch_data_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            err_count_q   <= err_count_d;
`ifdef LEVER_CHECKSUM_EN
            xor_q         <= xor_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        gap_d         = gap_q;
        shadow_d      = shadow_q;
        ch_data_d     = clear ? '0 : ch_data_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        err_count_d   = err_count_q;
`ifdef LEVER_CHECKSUM_EN
        xor_d         = xor_q;
`endif

        // Inter-byte watchdog, shared by every in-frame state.
        if (state_q != StIdle) begin
            if (rx_valid) begin
                gap_d = '0;
            end else if (gap_q == GapLast) begin
                frame_err_d = 1'b1;
                state_d     = StIdle;
            end else begin
                gap_d = gap_q + 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (rx_valid && rx_data == SYNC) begin
                    state_d = StPayload;
                    idx_d   = '0;
                    gap_d   = '0;
`ifdef LEVER_CHECKSUM_EN
                    xor_d   = '0;
`endif
                end
            end
            StPayload: begin
                if (rx_valid) begin
                    for (int unsigned i = 0; i < NBYTES; i++) begin
                        if (idx_q == IdxW'(i)) shadow_d[i*8 +: 8] = rx_data;
                    end
`ifdef LEVER_CHECKSUM_EN
                    xor_d = xor_q ^ rx_data;
`endif
                    if (idx_q == LastIdx) begin
`ifdef LEVER_CHECKSUM_EN
                        state_d = StCheck;
`else
                        // Commit overrides clear; the final byte is folded in directly.
                        ch_data_d     = shadow_d;
                        frame_valid_d = 1'b1;
                        state_d       = StIdle;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
`ifdef LEVER_CHECKSUM_EN
            StCheck: begin
                if (rx_valid) begin
                    if (rx_data == xor_q) begin
                        ch_data_d     = shadow_q;
                        frame_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = StIdle;
                end
            end
`endif
            default: state_d = StIdle;
        endcase

        if (frame_err_d && err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
    end

    assign ch_data     = ch_data_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign err_count   = err_count_q;
    assign busy        = (state_q != StIdle);
    assign db_state    = state_q;

endmodule

// File: tb/tb_lever_frame_decoder.sv
// Directed bench for lever_frame_decoder: a 2x16-bit instance and a 4x8-bit instance.
// Frames carry the trailing XOR byte only when LEVER_CHECKSUM_EN is defined.
module tb_lever_frame_decoder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        clear = 1'b0;
    logic [31:0] ch_data;
    logic        frame_valid, frame_err, busy;
    logic [7:0]  err_count;
    logic [1:0]  db_state;

    logic        rx_valid4 = 1'b0;
    logic [7:0]  rx_data4 = 8'h00;
    logic        clear4 = 1'b0;
    logic [31:0] ch_data4;
    logic        frame_valid4, frame_err4, busy4;
    logic [7:0]  err_count4;
    logic [1:0]  db_state4;

    int vectors = 0;
    int miscompares = 0;
    int exp_err = 0;

    always #5 clock = ~clock;

    lever_frame_decoder #(.N_CH(2), .W(16), .TIMEOUT(16), .SYNC(8'hA5)) dut (
        .clock(clock), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .clear(clear),
        .ch_data(ch_data), .frame_valid(frame_valid), .frame_err(frame_err),
        .err_count(err_count), .busy(busy), .db_state(db_state)
    );

    lever_frame_decoder #(.N_CH(4), .W(8), .TIMEOUT(16), .SYNC(8'hA5)) dut4 (
        .clock(clock), .reset(reset), .rx_valid(rx_valid4), .rx_data(rx_data4), .clear(clear4),
        .ch_data(ch_data4), .frame_valid(frame_valid4), .frame_err(frame_err4),
        .err_count(err_count4), .busy(busy4), .db_state(db_state4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; registered outputs are sampled there too.
    task automatic put(input logic [7:0] b);
        @(negedge clock);
        rx_valid = 1'b1;
        rx_data  = b;
    endtask

    task automatic idle();
        @(negedge clock);
        rx_valid = 1'b0;
    endtask

    task automatic put4(input logic [7:0] b);
        @(negedge clock);
        rx_valid4 = 1'b1;
        rx_data4  = b;
    endtask

    task automatic send4(input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3);
        put(8'hA5);
        put(b0);
        put(b1);
        put(b2);
        put(b3);
`ifdef LEVER_CHECKSUM_EN
        put(b0 ^ b1 ^ b2 ^ b3);
`endif
    endtask

    initial begin
        // Reset state.
        repeat (2) @(negedge clock);
        check("rst_ch_data", ch_data, 32'h0);
        check("rst_frame_valid", {31'b0, frame_valid}, 32'h0);
        check("rst_frame_err", {31'b0, frame_err}, 32'h0);
        check("rst_err_count", {24'b0, err_count}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_db_state", {30'b0, db_state}, 32'h0);
        reset = 1'b0;

        // Noise before sync is ignored.
        put(8'h00);
        put(8'h12);
        check("noise_busy", {31'b0, busy}, 32'h0);
        put(8'hFF);
        idle();
        idle();
        check("noise_err_count", {24'b0, err_count}, 32'h0);
        check("noise_db_state", {30'b0, db_state}, 32'h0);

        // First frame: A5,34,12,CD,AB(,40).
        put(8'hA5);
        put(8'h34);
        check("f1_db_state_payload", {30'b0, db_state}, 32'h1);
        check("f1_busy", {31'b0, busy}, 32'h1);
        put(8'h12);
        put(8'hCD);
        put(8'hAB);
`ifdef LEVER_CHECKSUM_EN
        put(8'h40);
        check("f1_db_state_check", {30'b0, db_state}, 32'h2);
`endif
        idle();
        check("f1_frame_valid", {31'b0, frame_valid}, 32'h1);
        check("f1_ch_data", ch_data, 32'hABCD_1234);
        check("f1_frame_err", {31'b0, frame_err}, 32'h0);
        check("f1_idle", {30'b0, db_state}, 32'h0);
        idle();
        check("f1_pulse_single", {31'b0, frame_valid}, 32'h0);
        check("f1_err_count", {24'b0, err_count}, 32'h0);

`ifdef LEVER_CHECKSUM_EN
        // Checksum mismatch.
        put(8'hA5);
        put(8'h34);
        put(8'h12);
        put(8'hCD);
        put(8'hAB);
        put(8'h41);
        idle();
        exp_err++;
        check("bad_chk_frame_err", {31'b0, frame_err}, 32'h1);
        check("bad_chk_frame_valid", {31'b0, frame_valid}, 32'h0);
        check("bad_chk_ch_data", ch_data, 32'hABCD_1234);
        idle();
        check("bad_chk_err_count", {24'b0, err_count}, 32'(exp_err));
        check("bad_chk_db_state", {30'b0, db_state}, 32'h0);
`endif

        // Timeout: A5,34 then idle; error appears after the 16th idle cycle.
        put(8'hA5);
        put(8'h34);
        repeat (16) idle();
        check("to_no_early_err", {31'b0, frame_err}, 32'h0);
        check("to_busy_before", {31'b0, busy}, 32'h1);
        idle();
        exp_err++;
        check("to_frame_err", {31'b0, frame_err}, 32'h1);
        check("to_busy_after", {31'b0, busy}, 32'h0);
        check("to_ch_data_kept", ch_data, 32'hABCD_1234);
        idle();
        check("to_err_count", {24'b0, err_count}, 32'(exp_err));
        check("to_err_pulse", {31'b0, frame_err}, 32'h0);

        // Back-to-back frames with zero gap.
        send4(8'h78, 8'h56, 8'h34, 8'h12);
        put(8'hA5);
        check("b2b_first_valid", {31'b0, frame_valid}, 32'h1);
        check("b2b_first_data", ch_data, 32'h1234_5678);
        put(8'hFF);
        check("b2b_first_pulse", {31'b0, frame_valid}, 32'h0);
        check("b2b_sync_taken", {30'b0, db_state}, 32'h1);
        put(8'hFF);
        put(8'h00);
        put(8'h80);
`ifdef LEVER_CHECKSUM_EN
        put(8'h80);
`endif
        idle();
        check("b2b_second_valid", {31'b0, frame_valid}, 32'h1);
        check("b2b_second_data", ch_data, 32'h8000_FFFF);
        idle();

        // clear alone zeroes ch_data.
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        check("clear_zero", ch_data, 32'h0);

        // clear during the commit cycle loses to the commit.
        send4(8'h34, 8'h12, 8'hCD, 8'hAB);
        clear = 1'b1;
        idle();
        clear = 1'b0;
        check("clear_commit_valid", {31'b0, frame_valid}, 32'h1);
        check("clear_commit_data", ch_data, 32'hABCD_1234);
        idle();

        // Reset mid-payload.
        put(8'hA5);
        put(8'h34);
        put(8'h12);
        @(negedge clock);
        rx_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        exp_err = 0;
        check("mid_rst_ch_data", ch_data, 32'h0);
        check("mid_rst_busy", {31'b0, busy}, 32'h0);
        check("mid_rst_err_count", {24'b0, err_count}, 32'h0);
        check("mid_rst_frame_err", {31'b0, frame_err}, 32'h0);
        reset = 1'b0;
        repeat (3) idle();
        check("mid_rst_no_err_after", {31'b0, frame_err}, 32'h0);
        check("mid_rst_idle", {30'b0, db_state}, 32'h0);

        // Four 8-bit channels.
        put4(8'hA5);
        put4(8'h01);
        put4(8'h02);
        put4(8'h03);
        put4(8'h04);
`ifdef LEVER_CHECKSUM_EN
        put4(8'h04);
`endif
        @(negedge clock);
        rx_valid4 = 1'b0;
        check("n4_frame_valid", {31'b0, frame_valid4}, 32'h1);
        check("n4_ch_data", ch_data4, 32'h0403_0201);

        // Saturation: 300 timed-out frames.
        for (int i = 0; i < 300; i++) begin
            put(8'hA5);
            repeat (17) idle();
        end
        idle();
        check("sat_err_count", {24'b0, err_count}, 32'd255);
        check("sat_ch_data_kept", ch_data, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
